pulse_train_gen: RTL

Programmable pulse-train transmitter: drives a single-bit output with a configurable number of rectangular pulses of configurable high width and rising-edge-to-rising-edge period, all counted in `clk` cycles. It is the transmit-side counterpart of the pulse edge detector. It produces synthetic R-wave-style pulses for loopback self-test and for stimulating external equipment. Every emitted pulse has at least one high cycle and at least one low cycle, so a one-flop rising-edge detector on the same clock detects each pulse exactly once.

---
 rtl/pulse_train_gen_pkg.sv | 13 +
 rtl/pulse_train_gen.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pulse_train_gen_pkg.sv
// Shared state encoding and constants for the pulse-train transmitter.
package pulse_train_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Shortest legal period: one high cycle plus one low cycle.
    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train transmitter: K pulses (or continuous) of clamped width/period.
// All outputs registered; first rising edge one cycle after start, abort effective next cycle, no backpressure.
module pulse_train_gen #(
    parameter int CNT_W = 24,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulses_sent
);
    import pulse_train_gen_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [NUM_W-1:0] num_lat;

    logic [CNT_W-1:0] eff_period;
    logic [CNT_W-1:0] eff_width;
    logic             last_phase;
    logic             train_end;

    // Clamp so every pulse has at least one high and one low cycle.
    always_comb begin
        eff_period = period;
        if (period < CNT_W'(MIN_PERIOD)) begin
            eff_period = CNT_W'(MIN_PERIOD);
        end
        eff_width = width;
        if (width == '0) begin
            eff_width = CNT_W'(1);
        end
        if (eff_width >= eff_period) begin
            eff_width = eff_period - CNT_W'(1);
        end
    end

    assign last_phase = (phase == CNT_W'(1));
    assign train_end  = (num_lat != '0) && (pulses_sent == num_lat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= '0;
            high_len    <= '0;
            low_len     <= '0;
            num_lat     <= '0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        high_len    <= eff_width;
                        low_len     <= eff_period - eff_width;
                        num_lat     <= num_pulses;
                        phase       <= eff_width;
                        // Count cleared and first rising edge counted together.
                        pulses_sent <= NUM_W'(1);
                        pulse_out   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        phase     <= '0;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                    end else if (last_phase) begin
                        state     <= ST_LOW;
                        phase     <= low_len;
                        pulse_out <= 1'b0;
                    end else begin
                        phase <= phase - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        phase     <= '0;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                    end else if (last_phase) begin
                        if (train_end) begin
                            state <= ST_IDLE;
                            phase <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_HIGH;
                            phase       <= high_len;
                            pulse_out   <= 1'b1;
                            pulses_sent <= pulses_sent + NUM_W'(1);
                        end
                    end else begin
                        phase <= phase - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    phase     <= '0;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
